// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: default field widths, chip-select polarity, opcodes and FSM state encoding
package spi_slave_pkg;
    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMMAND = 3'd1,
        ADDRESS = 3'd2,
        PAYLOAD = 3'd3,
        HOLD    = 3'd4
    } state_t;
endpackage

// File: rtl/spi_slave_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer plus registered edge detect for one asynchronous pin
//   sysclk, rst : system clock, synchronous active-high reset
//   pin         : asynchronous input
//   level       : synchronized level (third registered copy)
//   rise, fall  : one-cycle pulses, aligned with level
module spi_sync_edge (
    input  logic sysclk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    import spi_slave_pkg::*;
    logic s1, s2;
    always_ff @(posedge sysclk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            level <= s2;
            rise  <= s2 & ~level;
            fall  <= ~s2 & level;
        end
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 slave turning cmd/addr/payload frames into register-bus strobes
//   sysclk, rst               : system clock, synchronous active-high reset
//   cs, sclk, mosi            : asynchronous SPI pins (cs active low)
//   miso                      : serial read data to the master
//   wr_en, wr_addr, wr_data   : one-cycle write strobe with address/data
//   rd_en, rd_addr, rd_data   : one-cycle read request; rd_data valid the cycle after rd_en
//   busy                      : high while the FSM is out of IDLE
//   frame_err                 : one-cycle pulse on abort or unknown opcode
// SPI_SLAVE_READBACK_EN compiles in the READ opcode, rd_en/rd_addr and the miso path.
module spi_slave #(
    parameter int CMD_BITS     = spi_slave_pkg::CMD_BITS,
    parameter int ADDR_BITS    = spi_slave_pkg::ADDR_BITS,
    parameter int PAYLOAD_BITS = spi_slave_pkg::PAYLOAD_BITS
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    sclk,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    wr_en,
    output logic [ADDR_BITS-1:0]    wr_addr,
    output logic [PAYLOAD_BITS-1:0] wr_data,
    output logic                    rd_en,
    output logic [ADDR_BITS-1:0]    rd_addr,
    input  logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    busy,
    output logic                    frame_err
);
    import spi_slave_pkg::*;
    localparam int MAX_BITS = (CMD_BITS > ADDR_BITS)
        ? ((CMD_BITS > PAYLOAD_BITS) ? CMD_BITS : PAYLOAD_BITS)
        : ((ADDR_BITS > PAYLOAD_BITS) ? ADDR_BITS : PAYLOAD_BITS);
    localparam int CNT_W = $clog2(MAX_BITS);

    logic cs_level_unused, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_cs (
        .sysclk(sysclk), .rst(rst), .pin(cs),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge u_sclk (
        .sysclk(sysclk), .rst(rst), .pin(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge u_mosi (
        .sysclk(sysclk), .rst(rst), .pin(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CMD_BITS-1:0]     cmd_q, cmd_nxt;
    logic [ADDR_BITS-1:0]    addr_q, addr_nxt;
    logic [PAYLOAD_BITS-1:0] data_q, data_nxt;
    logic cs_on, cs_off, field_last, step, in_field;
    logic wr_op, rd_op, rd_op_nxt, cmd_ok;
    logic wr_go, rd_go, err_go;

    assign cs_on      = CS_ASSERT ? cs_rise : cs_fall;
    assign cs_off     = CS_DEASSERT ? cs_rise : cs_fall;
    assign cmd_nxt    = {cmd_q[CMD_BITS-2:0], mosi_lvl};
    assign addr_nxt   = {addr_q[ADDR_BITS-2:0], mosi_lvl};
    assign data_nxt   = {data_q[PAYLOAD_BITS-2:0], mosi_lvl};
    assign in_field   = state inside {COMMAND, ADDRESS, PAYLOAD};
    assign field_last = cnt == CNT_W'(((state == COMMAND) ? CMD_BITS
                                     : (state == ADDRESS) ? ADDR_BITS : PAYLOAD_BITS) - 1);
    assign step       = sclk_rise & field_last;
    assign wr_op      = cmd_q == CMD_BITS'(CMD_WRITE);
    assign cmd_ok     = (cmd_nxt == CMD_BITS'(CMD_WRITE)) | rd_op_nxt;
    assign busy       = state != IDLE;

`ifdef SPI_SLAVE_READBACK_EN
    assign rd_op_nxt = cmd_nxt == CMD_BITS'(CMD_READ);
    assign rd_op     = cmd_q == CMD_BITS'(CMD_READ);
`else
    assign rd_op_nxt = 1'b0;
    assign rd_op     = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A completing payload wins over a cs release seen in the same cycle.
    always_comb begin
        state_nxt = state;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        err_go    = 1'b0;
        case (state)
            IDLE: state_nxt = cs_on ? COMMAND : IDLE;
            COMMAND: begin
                if (cs_off) begin
                    state_nxt = IDLE;
                    err_go    = 1'b1;
                end else if (step) begin
                    state_nxt = cmd_ok ? ADDRESS : HOLD;
                    err_go    = ~cmd_ok;
                end
            end
            ADDRESS: begin
                if (cs_off) begin
                    state_nxt = IDLE;
                    err_go    = 1'b1;
                end else if (step) begin
                    state_nxt = PAYLOAD;
                    rd_go     = rd_op;
                end
            end
            PAYLOAD: begin
                if (step) begin
                    state_nxt = cs_off ? IDLE : HOLD;
                    wr_go     = wr_op;
                end else if (cs_off) begin
                    state_nxt = IDLE;
                    err_go    = 1'b1;
                end
            end
            HOLD:    state_nxt = cs_off ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt       <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= (state_nxt != state) ? '0 : cnt + CNT_W'(sclk_rise & in_field);
            cmd_q     <= (sclk_rise && state == COMMAND) ? cmd_nxt : cmd_q;
            addr_q    <= (sclk_rise && state == ADDRESS) ? addr_nxt : addr_q;
            data_q    <= (sclk_rise && state == PAYLOAD) ? data_nxt : data_q;
            wr_en     <= wr_go;
            wr_addr   <= wr_go ? addr_q : wr_addr;
            wr_data   <= wr_go ? data_nxt : wr_data;
            frame_err <= err_go;
        end
    end

`ifdef SPI_SLAVE_READBACK_EN
    logic                    rd_load, miso_q;
    logic [PAYLOAD_BITS-1:0] tx_q;
    // rd_data is sampled one cycle after rd_en; the sclk half-period bound
    // keeps this ahead of the first payload falling edge.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rd_load <= 1'b0;
            tx_q    <= '0;
            miso_q  <= 1'b0;
        end else begin
            rd_en   <= rd_go;
            rd_addr <= rd_go ? addr_nxt : rd_addr;
            rd_load <= rd_en;
            tx_q    <= rd_load ? rd_data
                     : (state == PAYLOAD && sclk_fall && rd_op) ? {tx_q[PAYLOAD_BITS-2:0], 1'b0} : tx_q;
            miso_q  <= (state != PAYLOAD) ? 1'b0
                     : (sclk_fall && rd_op) ? tx_q[PAYLOAD_BITS-1] : miso_q;
        end
    end
    assign miso = miso_q & (state == PAYLOAD);
`else
    logic [PAYLOAD_BITS+1:0] readback_unused;
    assign readback_unused = {rd_go, sclk_fall, rd_data};
    assign miso    = 1'b0;
    assign rd_en   = 1'b0;
    assign rd_addr = '0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI frames against an event-timing reference model
module tb_spi_slave;
    import spi_slave_pkg::*;
    localparam int MAXC = 60000;
`ifdef SPI_SLAVE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic sysclk = 1'b0, rst = 1'b1, cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic miso, wr_en, rd_en, busy, frame_err;
    logic [7:0] wr_addr, wr_data, rd_addr;
    int checks = 0, failures = 0, cyc = 0;
    int wr_seen = 0, rd_seen = 0, err_seen = 0;
    bit chk_en = 1'b0;
    bit e_wr[MAXC], e_rd[MAXC], e_err[MAXC], e_busy[MAXC], e_miso_ok[MAXC];
    logic [7:0] e_wa[MAXC], e_wd[MAXC], e_ra[MAXC];
    logic [7:0] mem[256];
    logic [7:0] last_wa = 8'h00, last_wd = 8'h00, last_ra = 8'h00;

    spi_slave dut (
        .sysclk(sysclk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .frame_err(frame_err)
    );

    always #4 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // register bus: data is valid only in the cycle after rd_en
    always @(posedge sysclk) begin
        if (rd_en === 1'b1) begin
            logic [7:0] a;
            a = rd_addr;
            #1 rd_data = mem[a];
            @(posedge sysclk);
            #1 rd_data = 8'($urandom);
        end
    end

    always @(negedge sysclk) begin
        if (chk_en && cyc < MAXC) begin
            chk("wr_en", wr_en, e_wr[cyc]);
            chk("rd_en", rd_en, e_rd[cyc]);
            chk("frame_err", frame_err, e_err[cyc]);
            chk("busy", busy, e_busy[cyc]);
            if (!e_miso_ok[cyc]) chk("miso_quiet", miso, 0);
            if (e_wr[cyc]) begin
                chk("wr_addr", wr_addr, e_wa[cyc]);
                chk("wr_data", wr_data, e_wd[cyc]);
            end
            if (e_rd[cyc]) chk("rd_addr", rd_addr, e_ra[cyc]);
            if (wr_en) begin wr_seen++; last_wa = wr_addr; last_wd = wr_data; end
            if (rd_en) begin rd_seen++; last_ra = rd_addr; end
            if (frame_err) err_seen++;
        end
    end

    function automatic void mark_range(input int a, input int b, input bit is_busy);
        for (int i = a; i < b && i < MAXC; i++) begin
            if (is_busy) e_busy[i] = 1'b1;
            else e_miso_ok[i] = 1'b1;
        end
    endfunction

    // Model: each pin edge is seen 3 cycles later, every strobe/pulse 1 cycle after that.
    function automatic void model(input logic [7:0] c, a, d, input int k0, nbits, half, input bit simul);
        bit wr_op, rd_op;
        int ke, r7, r15, r23;
        wr_op = c == CMD_WRITE;
        rd_op = RB && c == CMD_READ;
        r7  = k0 + half * 15;
        r15 = k0 + half * 31;
        r23 = k0 + half * 47;
        ke  = simul ? k0 + half * (2 * nbits - 1) : k0 + half * (2 * nbits + 1);
        mark_range(k0 + 4, ke + 4, 1'b1);
        if (nbits >= 8 && !(wr_op || rd_op)) begin
            e_err[r7 + 4] = 1'b1;
        end else begin
            if (rd_op && nbits >= 16) begin
                e_rd[r15 + 4] = 1'b1;
                e_ra[r15 + 4] = a;
                mark_range(r15 + 4, (nbits >= 24) ? r23 + 4 : ke + 4, 1'b0);
            end
            if (nbits >= 24 && wr_op) begin
                e_wr[r23 + 4] = 1'b1;
                e_wa[r23 + 4] = a;
                e_wd[r23 + 4] = d;
            end
            if (nbits < 24) e_err[ke + 4] = 1'b1;
        end
    endfunction

    task automatic send_frame(input logic [7:0] c, a, d, input int nbits, half, input bit simul,
                              input int rst_bit, output logic [7:0] rx);
        logic [MASTER_FRAME_WIDTH-1:0] f;
        f  = {c, a, d};
        rx = 8'h00;
        if (rst_bit < 0) model(c, a, d, cyc, nbits, half, simul);
        else chk_en = 1'b0;
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                tick(1);
                chk_en = 1'b1;
                tick(2);
                rst = 1'b0;
            end
            mosi = (i < MASTER_FRAME_WIDTH) ? f[MASTER_FRAME_WIDTH-1-i] : 1'($urandom);
            tick(half);
            if (i >= 16 && i < 24) rx = {rx[6:0], miso};
            sclk = 1'b1;
            if (simul && i == nbits - 1) cs = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
        if (!simul) begin
            tick(half);
            cs = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rx, c, a, d;
        int w0, r0, e0, nb, hf;
        bit sm;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h05] = 8'h2A;
        tick(3);
        chk("rst_miso", miso, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk_en = 1'b1;
        rst = 1'b0;
        tick(8);

        w0 = wr_seen;
        send_frame(8'h02, 8'h05, 8'h55, 24, 4, 1'b0, -1, rx);
        tick(8);
        chk("t_write_count", wr_seen - w0, 1);
        chk("t_write_addr", last_wa, 8'h05);
        chk("t_write_data", last_wd, 8'h55);

        w0 = wr_seen; r0 = rd_seen; e0 = err_seen;
        send_frame(8'h03, 8'h05, 8'h00, 24, 5, 1'b0, -1, rx);
        tick(8);
        chk("t_read_no_write", wr_seen - w0, 0);
        if (RB) begin
            chk("t_read_rx", rx, 8'h2A);
            chk("t_read_count", rd_seen - r0, 1);
            chk("t_read_addr", last_ra, 8'h05);
        end else begin
            chk("t_read_disabled_rx", rx, 8'h00);
            chk("t_read_disabled_err", err_seen - e0, 1);
        end

        w0 = wr_seen; r0 = rd_seen; e0 = err_seen;
        send_frame(8'hFF, 8'h05, 8'h55, 24, 4, 1'b0, -1, rx);
        tick(8);
        chk("t_badop_err", err_seen - e0, 1);
        chk("t_badop_strobes", (wr_seen - w0) + (rd_seen - r0), 0);
        chk("t_badop_busy", busy, 0);

        w0 = wr_seen; e0 = err_seen;
        send_frame(8'h02, 8'h07, 8'hAA, 12, 4, 1'b0, -1, rx);
        tick(4);
        send_frame(8'h02, 8'h07, 8'hAA, 24, 4, 1'b0, -1, rx);
        tick(8);
        chk("t_abort_err", err_seen - e0, 1);
        chk("t_abort_count", wr_seen - w0, 1);
        chk("t_abort_next", {last_wa, last_wd}, 16'h07AA);

        w0 = wr_seen;
        send_frame(8'h02, 8'h66, 8'h77, 24, 4, 1'b0, 10, rx);
        tick(6);
        send_frame(8'h02, 8'h09, 8'h3C, 24, 4, 1'b0, -1, rx);
        tick(8);
        chk("t_rst_count", wr_seen - w0, 1);
        chk("t_rst_next", {last_wa, last_wd}, 16'h093C);

        w0 = wr_seen;
        send_frame(8'h02, 8'h11, 8'h22, 24, 4, 1'b0, -1, rx);
        tick(4);
        send_frame(8'h02, 8'h33, 8'h44, 24, 4, 1'b0, -1, rx);
        tick(8);
        chk("t_b2b_count", wr_seen - w0, 2);
        chk("t_b2b_last", {last_wa, last_wd}, 16'h3344);

        w0 = wr_seen; e0 = err_seen;
        send_frame(8'h02, 8'h44, 8'h99, 24, 4, 1'b1, -1, rx);
        tick(8);
        chk("t_simul_count", wr_seen - w0, 1);
        chk("t_simul_err", err_seen - e0, 0);

        send_frame(8'h02, 8'h5A, 8'hC3, 26, 4, 1'b0, -1, rx);
        tick(8);
        chk("t_extra_bits", {last_wa, last_wd}, 16'h5AC3);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: c = CMD_WRITE;
                1: c = CMD_READ;
                default: c = 8'($urandom);
            endcase
            a  = 8'($urandom);
            d  = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 26) : 24;
            hf = $urandom_range(4, 6);
            sm = nb == 24 && $urandom_range(0, 5) == 0;
            send_frame(c, a, d, nb, hf, sm, -1, rx);
            if (RB && c == CMD_READ && nb >= 24) chk("rand_read_rx", rx, mem[a]);
            tick($urandom_range(4, 8));
        end
        tick(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(8 * 90000);
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end
endmodule
